// File: rtl/fact_engine_if.sv
// Control/operand and result/status bundle between the register file and the factorial core.
interface fact_engine_if #(
    parameter int unsigned DATA_W = 64
);
    logic              op_start;
    logic              op_clear;
    logic              intr_en;
    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] result_h;
    logic [DATA_W-1:0] result_l;
    logic [1:0]        opdone;
    logic              busy;
    logic              interrupt;

    modport slave (
        input  op_start, op_clear, intr_en, operand,
        output result_h, result_l, opdone, busy, interrupt
    );

    modport master (
        output op_start, op_clear, intr_en, operand,
        input  result_h, result_l, opdone, busy, interrupt
    );
endinterface

// File: rtl/fact_engine.sv
// Iterative factorial core: N! mod 2^(2*DATA_W) using a radix-2 shift-add multiplier,
// one multiplier bit per MUL cycle and one NEXT cycle per factor.
module fact_engine #(
    parameter int unsigned DATA_W = 64
) (
    input logic           clk,
    input logic           reset_n,
    fact_engine_if.slave  bus
);
    localparam int unsigned ResW = 2 * DATA_W;
    localparam int unsigned ShW  = $clog2(DATA_W);

    typedef enum logic [2:0] {
        Idle,
        Init,
        Mul,
        Next,
        Done
    } state_t;

    state_t            stateQ;
    state_t            stateD;
    logic [ResW-1:0]   accQ;
    logic [ResW-1:0]   partialQ;
    logic [ResW-1:0]   resultQ;
    logic [DATA_W-1:0] kQ;
    logic [DATA_W-1:0] multQ;
    logic [ShW-1:0]    shiftQ;
    logic              doneQ;
    logic              busyQ;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stateQ <= Idle;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state logic; op_clear wins over everything
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            Idle: if (bus.op_start && !doneQ) stateD = Init;
            Init: stateD = (kQ <= DATA_W'(1)) ? Done : Mul;
            Mul:  if (multQ[DATA_W-1:1] == '0) stateD = Next;
            Next: stateD = (kQ <= DATA_W'(2)) ? Done : Mul;
            Done: stateD = Done;
            default: stateD = Idle;
        endcase
        if (bus.op_clear) stateD = Idle;
    end

    // Datapath; the operand is captured straight into the factor counter k
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            accQ     <= '0;
            partialQ <= '0;
            resultQ  <= '0;
            kQ       <= '0;
            multQ    <= '0;
            shiftQ   <= '0;
            doneQ    <= 1'b0;
            busyQ    <= 1'b0;
        end else if (bus.op_clear) begin
            accQ     <= '0;
            partialQ <= '0;
            resultQ  <= '0;
            kQ       <= '0;
            multQ    <= '0;
            shiftQ   <= '0;
            doneQ    <= 1'b0;
            busyQ    <= 1'b0;
        end else begin
            busyQ <= (stateD == Init) || (stateD == Mul) || (stateD == Next);
            case (stateQ)
                Idle: begin
                    if (stateD == Init) kQ <= bus.operand;
                end
                Init: begin
                    accQ     <= ResW'(1);
                    multQ    <= kQ;
                    shiftQ   <= '0;
                    partialQ <= '0;
                    if (stateD == Done) begin
                        resultQ <= ResW'(1);
                        doneQ   <= 1'b1;
                    end
                end
                Mul: begin
                    if (multQ[0]) partialQ <= partialQ + (accQ << shiftQ);
                    multQ  <= multQ >> 1;
                    shiftQ <= shiftQ + ShW'(1);
                end
                Next: begin
                    accQ <= partialQ;
                    kQ   <= kQ - DATA_W'(1);
                    // Last product goes straight to the result on DONE entry
                    if (stateD == Done) begin
                        resultQ <= partialQ;
                        doneQ   <= 1'b1;
                    end else begin
                        multQ    <= kQ - DATA_W'(1);
                        shiftQ   <= '0;
                        partialQ <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result_h  = resultQ[ResW-1:DATA_W];
    assign bus.result_l  = resultQ[DATA_W-1:0];
    assign bus.busy      = busyQ;
    // Interrupt qualifier follows intr_en combinationally while done is set
    assign bus.interrupt = doneQ & bus.intr_en;
    assign bus.opdone    = {doneQ & bus.intr_en, doneQ};
endmodule

// File: tb/tb_fact_engine.sv
// Directed bench for fact_engine: latency, results, clear/reset abort, no-restart and interrupt tracking.
module tb_fact_engine;
    localparam int unsigned DW = 64;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    int   lat;
    bit   ok;
    int   sawBusy;

    fact_engine_if #(.DATA_W(DW)) bus ();

    fact_engine #(.DATA_W(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for done with a cycle budget; latency counts the accepting edge as 1
    task automatic waitDone(input int budget, output int cyc, output bit got);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
            got = bus.opdone[0];
        end
        if (!got) begin
            checks++;
            errors++;
            $error("FAIL timeout: observed=no done expected=done within %0d cycles", budget);
        end
    endtask

    task automatic startOp(input logic [DW-1:0] n);
        @(negedge clk);
        bus.operand  = n;
        bus.op_start = 1'b1;
    endtask

    task automatic clearPulse();
        @(negedge clk);
        bus.op_start = 1'b0;
        bus.op_clear = 1'b1;
        @(negedge clk);
        bus.op_clear = 1'b0;
    endtask

    task automatic checkZero(input string tag);
        check({tag, ".res"}, {bus.result_h, bus.result_l}, 128'd0);
        check({tag, ".status"}, {bus.opdone, bus.busy, bus.interrupt}, 4'b0000);
    endtask

    initial begin
        reset_n      = 1'b0;
        bus.op_start = 1'b0;
        bus.op_clear = 1'b0;
        bus.intr_en  = 1'b0;
        bus.operand  = '0;
        repeat (3) @(negedge clk);
        checkZero("reset");
        reset_n = 1'b1;

        // 0! and 1!: two-cycle latency, result 1
        startOp(64'd0);
        waitDone(20, lat, ok);
        check("n0.lat", 128'(lat), 128'd2);
        check("n0.res", {bus.result_h, bus.result_l}, 128'd1);
        check("n0.opdone", 128'(bus.opdone), 128'b01);
        check("n0.irq", 128'(bus.interrupt), 128'd0);
        clearPulse();
        checkZero("clr0");
        startOp(64'd1);
        waitDone(20, lat, ok);
        check("n1.lat", 128'(lat), 128'd2);
        check("n1.res", {bus.result_h, bus.result_l}, 128'd1);
        check("n1.opdone", 128'(bus.opdone), 128'b01);
        clearPulse();

        // 5! with interrupt enabled; operand change after capture must be ignored
        bus.intr_en = 1'b1;
        startOp(64'd5);
        @(posedge clk);
        #1;
        bus.operand = 64'd9;
        waitDone(40, lat, ok);
        check("n5.lat", 128'(lat + 1), 128'd16);
        check("n5.res", {bus.result_h, bus.result_l}, 128'd120);
        check("n5.opdone", 128'(bus.opdone), 128'b11);
        check("n5.irq", 128'(bus.interrupt), 128'd1);
        clearPulse();
        bus.intr_en = 1'b0;

        // 21! overflows the low word; 20! fits
        startOp(64'd21);
        waitDone(200, lat, ok);
        check("n21.res", {bus.result_h, bus.result_l}, {64'h2, 64'hC5077D36B8C40000});
        clearPulse();
        startOp(64'd20);
        waitDone(200, lat, ok);
        check("n20.lat", 128'(lat), 128'd94);
        check("n20.res", {bus.result_h, bus.result_l}, {64'h0, 64'h21C3677C82B40000});
        clearPulse();

        // Async reset mid-MUL, then a clean restart
        startOp(64'd20);
        repeat (10) @(negedge clk);
        check("mid.busy", 128'(bus.busy), 128'd1);
        reset_n = 1'b0;
        #1;
        checkZero("areset");
        @(negedge clk);
        bus.op_start = 1'b0;
        reset_n = 1'b1;
        startOp(64'd20);
        waitDone(200, lat, ok);
        check("rst.n20", {bus.result_h, bus.result_l}, {64'h0, 64'h21C3677C82B40000});
        clearPulse();

        // op_clear aborts 10!; op_start held high restarts it
        startOp(64'd10);
        repeat (8) @(negedge clk);
        bus.op_clear = 1'b1;
        @(posedge clk);
        #1;
        checkZero("abort");
        @(negedge clk);
        bus.op_clear = 1'b0;
        waitDone(200, lat, ok);
        check("n10.res", {bus.result_h, bus.result_l}, 128'h375F00);
        sawBusy = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.busy) sawBusy++;
        end
        check("hold.busy", 128'(sawBusy), 128'd0);
        check("hold.done", 128'(bus.opdone), 128'b01);
        check("hold.res", {bus.result_h, bus.result_l}, 128'h375F00);

        // Clear and start together in IDLE: clear wins
        @(negedge clk);
        bus.op_clear = 1'b1;
        repeat (3) @(negedge clk);
        checkZero("clrstart");
        bus.op_clear = 1'b0;
        bus.op_start = 1'b0;

        // Interrupt follows intr_en while done
        startOp(64'd3);
        waitDone(40, lat, ok);
        check("n3.res", {bus.result_h, bus.result_l}, 128'd6);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.intr_en = (i % 2) == 0;
            #1;
            check("irq.track", {bus.interrupt, bus.opdone}, {bus.intr_en, bus.intr_en, 1'b1});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
